hazard_ctrl: RTL and testbench

Pipeline hazard controller. It drives the hold (write-inhibit) input of the IF/ID pipeline register, the PC write enable, the ID/EX bubble and the IF/ID flush. It resolves load-use hazards, taken-branch flushes and multi-cycle divide stalls. It sits beside the ID stage and is the producer of the hold signal that the IF/ID register consumes (1 = hold contents).

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/hazard_ctrl_div_timer.sv | 54 +++++
 rtl/hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared definitions for the pipeline hazard controller:
//             FSM state encoding, divider timing default, the NOP word the
//             ID/EX register loads on a bubble, and the source/destination
//             register match helper used for load-use detection.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Controller FSM encoding
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_DIV = 1'b1;

  // Divider latency default and countdown width default
  localparam int unsigned DIV_CYCLES_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT      = 6;

  // Instruction word the ID/EX register substitutes when Bubble=1
  // (sll $0,$0,0 - the canonical all-zero NOP).
  localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;

  // A source operand collides with the EX destination only when it is
  // actually read and the destination is not the hard-wired zero register.
  function automatic logic src_hazard(input logic       used,
                                      input logic [4:0] src,
                                      input logic [4:0] dst);
    return used && (src == dst) && (dst != 5'd0);
  endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_div_timer.sv
`default_nettype none
// ============================================================================
//  Module   : div_timer
//  Purpose  : Loadable down-counter that tracks the remaining divider
//             cycles. Decrements every cycle while non-zero; clear has
//             priority over load.
//  Ports    : Clk        - clock
//             Clrn       - asynchronous active-low reset
//             load_i     - load load_val_i into the counter
//             clear_i    - force the counter to zero
//             load_val_i - value loaded on load_i
//             count_o    - current counter value
//             zero_o     - counter equals zero
//  Revision : 1.0 - initial release
// ============================================================================
module div_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule : div_timer
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard controller beside the ID stage. Resolves
//             taken-branch flushes, load-use hazards and multi-cycle divide
//             stalls; drives IF/ID hold, PC write enable, ID/EX bubble and
//             IF/ID flush.
//  Ports    : Clk, Clrn              - clock, async active-low reset
//             ID_rs/ID_rt            - source fields of the ID instruction
//             ID_use_rs/ID_use_rt    - source actually read
//             ID_is_div              - ID instruction is a divide
//             EX_rd, EX_mem_read     - EX destination / EX is a load
//             EX_branch_taken        - EX branch resolved taken
//             Stall                  - IF/ID hold (1 = keep contents)
//             PC_we                  - PC write enable
//             Bubble                 - ID/EX loads NOP
//             Flush                  - IF/ID cleared at next edge
//             Div_start              - one-cycle divider start pulse
//             Busy                   - divide in progress (registered)
//             Stall_cnt              - saturating count of stalled edges
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_use_rs,
  input  logic        ID_use_rt,
  input  logic        ID_is_div,
  input  logic [4:0]  EX_rd,
  input  logic        EX_mem_read,
  input  logic        EX_branch_taken,
  output logic        Stall,
  output logic        PC_we,
  output logic        Bubble,
  output logic        Flush,
  output logic        Div_start,
  output logic        Busy,
  output logic [15:0] Stall_cnt
);

  // Start cycle is separate, so the countdown covers DIV_CYCLES cycles in
  // DIV when it is loaded with DIV_CYCLES-1 and exits on reaching zero.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [0:0]  state_q, state_d;
  logic        run_q;
  logic        div_done_q, div_done_d;
  logic        busy_q;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic             load_use;
  logic             tmr_load;
  logic             tmr_clear;
  logic             tmr_zero;
  logic [CNT_W-1:0] tmr_count;

  logic stall_c, pc_we_c, bubble_c, flush_c, div_start_c;

  assign load_use = EX_mem_read &&
                    (src_hazard(ID_use_rs, ID_rs, EX_rd) ||
                     src_hazard(ID_use_rt, ID_rt, EX_rd));

  div_timer #(
    .CNT_W (CNT_W)
  ) u_div_timer (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .load_i     (tmr_load),
    .clear_i    (tmr_clear),
    .load_val_i (DIV_LOAD),
    .count_o    (tmr_count),
    .zero_o     (tmr_zero)
  );

  // Output muxing and next-state logic. Everything is held at zero until
  // run_q sets, which keeps the PC frozen for the first edge after reset.
  always_comb begin
    state_d     = state_q;
    div_done_d  = 1'b0;
    tmr_load    = 1'b0;
    tmr_clear   = 1'b0;
    stall_c     = 1'b0;
    pc_we_c     = 1'b0;
    bubble_c    = 1'b0;
    flush_c     = 1'b0;
    div_start_c = 1'b0;

    if (run_q) begin
      case (state_q)
        ST_RUN: begin
          if (EX_branch_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            pc_we_c  = 1'b1;
          end else if (load_use) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
          end else if (ID_is_div && !div_done_q) begin
            // div_done_q marks the divide that just finished, so the held
            // instruction advances instead of launching a second divide.
            div_start_c = 1'b1;
            stall_c     = 1'b1;
            bubble_c    = 1'b1;
            tmr_load    = 1'b1;
            state_d     = ST_DIV;
          end else begin
            pc_we_c = 1'b1;
          end
        end
        ST_DIV: begin
          if (EX_branch_taken) begin
            // Wrong-path divide: abandon it, counter cleared, no done mark.
            flush_c   = 1'b1;
            bubble_c  = 1'b1;
            pc_we_c   = 1'b1;
            tmr_clear = 1'b1;
            state_d   = ST_RUN;
          end else begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            if (tmr_zero) begin
              state_d    = ST_RUN;
              div_done_d = 1'b1;
            end
          end
        end
        default: begin
          state_d   = ST_RUN;
          tmr_clear = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q     <= ST_RUN;
      run_q       <= 1'b0;
      div_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      div_done_q  <= div_done_d;
      busy_q      <= (state_d == ST_DIV);
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall     = stall_c;
  assign PC_we     = pc_we_c;
  assign Bubble    = bubble_c;
  assign Flush     = flush_c;
  assign Div_start = div_start_c;
  assign Busy      = busy_q;
  assign Stall_cnt = stall_cnt_q;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Directed self-checking bench for hazard_ctrl (DIV_CYCLES=4).
//             Inputs change 1 ns after a rising edge; outputs are compared
//             1 ns later, well away from the next edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic [4:0]  ID_rs, ID_rt, EX_rd;
  logic        ID_use_rs, ID_use_rt, ID_is_div, EX_mem_read, EX_branch_taken;
  logic        Stall, PC_we, Bubble, Flush, Div_start, Busy;
  logic [15:0] Stall_cnt;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  hazard_ctrl #(
    .DIV_CYCLES (4),
    .CNT_W      (6)
  ) dut (
    .Clk             (Clk),
    .Clrn            (Clrn),
    .ID_rs           (ID_rs),
    .ID_rt           (ID_rt),
    .ID_use_rs       (ID_use_rs),
    .ID_use_rt       (ID_use_rt),
    .ID_is_div       (ID_is_div),
    .EX_rd           (EX_rd),
    .EX_mem_read     (EX_mem_read),
    .EX_branch_taken (EX_branch_taken),
    .Stall           (Stall),
    .PC_we           (PC_we),
    .Bubble          (Bubble),
    .Flush           (Flush),
    .Div_start       (Div_start),
    .Busy            (Busy),
    .Stall_cnt       (Stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the five combinational controls plus Busy in one go.
  task automatic chk_ctl(input string tag, input logic st, input logic pc,
                         input logic bu, input logic fl, input logic ds,
                         input logic by);
    chk({tag, ".Stall"},     {31'd0, Stall},     {31'd0, st});
    chk({tag, ".PC_we"},     {31'd0, PC_we},     {31'd0, pc});
    chk({tag, ".Bubble"},    {31'd0, Bubble},    {31'd0, bu});
    chk({tag, ".Flush"},     {31'd0, Flush},     {31'd0, fl});
    chk({tag, ".Div_start"}, {31'd0, Div_start}, {31'd0, ds});
    chk({tag, ".Busy"},      {31'd0, Busy},      {31'd0, by});
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; EX_rd = 5'd0;
    ID_use_rs = 1'b0; ID_use_rt = 1'b0; ID_is_div = 1'b0;
    EX_mem_read = 1'b0; EX_branch_taken = 1'b0;
  endtask

  task automatic set_load_use_rs5();
    EX_mem_read = 1'b1; EX_rd = 5'd5; ID_rs = 5'd5; ID_use_rs = 1'b1;
  endtask

  initial begin
    idle_inputs();
    Clrn = 1'b0;

    // ---------------- reset / startup ----------------
    EX_branch_taken = 1'b1;  // must be ignored while in reset
    set_load_use_rs5();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ctl("reset", 0, 0, 0, 0, 0, 0);
      chk("reset.Stall_cnt", {16'd0, Stall_cnt}, 32'd0);
    end
    idle_inputs();
    Clrn = 1'b1;             // released mid-cycle
    #1;
    chk_ctl("release", 0, 0, 0, 0, 0, 0);
    tick();                  // first edge after release sets run_q
    chk_ctl("run", 0, 1, 0, 0, 0, 0);
    chk("run.Stall_cnt", {16'd0, Stall_cnt}, 32'd0);

    // ---------------- load-use ----------------
    set_load_use_rs5();
    #1;
    chk_ctl("lu_rs", 1, 0, 1, 0, 0, 0);
    tick();
    idle_inputs();
    #1;
    chk_ctl("lu_after", 0, 1, 0, 0, 0, 0);
    chk("lu.Stall_cnt", {16'd0, Stall_cnt}, 32'd1);

    EX_mem_read = 1'b1; EX_rd = 5'd7; ID_rt = 5'd7; ID_use_rt = 1'b1;
    #1;
    chk_ctl("lu_rt", 1, 0, 1, 0, 0, 0);
    ID_use_rt = 1'b0;        // matching field that is not read
    #1;
    chk_ctl("lu_rt_unused", 0, 1, 0, 0, 0, 0);
    EX_rd = 5'd0; ID_rs = 5'd0; ID_use_rs = 1'b1; ID_rt = 5'd0; ID_use_rt = 1'b1;
    #1;
    chk_ctl("lu_r0", 0, 1, 0, 0, 0, 0);
    set_load_use_rs5(); EX_mem_read = 1'b0;  // ALU producer, no hazard
    #1;
    chk_ctl("lu_noload", 0, 1, 0, 0, 0, 0);
    idle_inputs();
    #1;
    chk("lu2.Stall_cnt", {16'd0, Stall_cnt}, 32'd1);

    // ---------------- divide, held ID_is_div ----------------
    ID_is_div = 1'b1;
    #1;
    chk_ctl("div_start", 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_ctl($sformatf("div_wait%0d", i), 1, 0, 1, 0, 0, 1);
    end
    tick();
    chk_ctl("div_done", 0, 1, 0, 0, 0, 0);
    chk("div.Stall_cnt", {16'd0, Stall_cnt}, 32'd6);
    ID_is_div = 1'b0;
    tick();

    // ---------------- branch priority ----------------
    set_load_use_rs5();
    ID_is_div = 1'b1;
    EX_branch_taken = 1'b1;
    #1;
    chk_ctl("br_prio", 0, 1, 1, 1, 0, 0);
    tick();
    idle_inputs();
    #1;
    chk("br.Stall_cnt", {16'd0, Stall_cnt}, 32'd6);

    // ---------------- abort mid-divide ----------------
    ID_is_div = 1'b1;
    #1;
    chk_ctl("ab_start", 1, 0, 1, 0, 1, 0);
    tick();                  // DIV cycle 1
    tick();                  // DIV cycle 2
    ID_is_div = 1'b0;
    EX_branch_taken = 1'b1;
    #1;
    chk_ctl("ab_flush", 0, 1, 1, 1, 0, 1);
    tick();
    EX_branch_taken = 1'b0;
    #1;
    chk_ctl("ab_after", 0, 1, 0, 0, 0, 0);
    chk("ab.Stall_cnt", {16'd0, Stall_cnt}, 32'd8);

    // ---------------- reset mid-divide ----------------
    ID_is_div = 1'b1;
    #1;
    chk_ctl("rs_start", 1, 0, 1, 0, 1, 0);
    tick();
    tick();
    chk("rs.Busy_pre", {31'd0, Busy}, 32'd1);
    Clrn = 1'b0;
    #1;
    chk_ctl("rs_mid", 0, 0, 0, 0, 0, 0);
    chk("rs.state", {31'd0, dut.state_q}, 32'd0);
    chk("rs.Stall_cnt", {16'd0, Stall_cnt}, 32'd0);
    tick();
    ID_is_div = 1'b0;
    Clrn = 1'b1;
    tick();
    chk_ctl("rs_run", 0, 1, 0, 0, 0, 0);

    // ---------------- saturation ----------------
    set_load_use_rs5();
    repeat (70000) @(posedge Clk);
    #1;
    chk("sat.Stall_cnt", {16'd0, Stall_cnt}, 32'h0000FFFF);
    chk("sat.Stall", {31'd0, Stall}, 32'd1);
    tick();
    chk("sat_hold.Stall_cnt", {16'd0, Stall_cnt}, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
